// File: rtl/l2_bank_pkg.sv
// Shared types and helpers for the L2 bank front-end.
package l2_bank_pkg;

    typedef enum logic {
        INIT,
        SERVE
    } l2_bank_state_e;

    localparam int MAX_READ_LATENCY = 4;

    function automatic int be_width(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/l2_bank_rsp_pipe.sv
// Fixed-depth valid/error shift register aligning TCDM responses with SRAM read latency.
module l2_bank_rsp_pipe
    import l2_bank_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic err_i,
    output logic valid_o,
    output logic err_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] err_q, err_d;

    if (DEPTH < 1 || DEPTH > MAX_READ_LATENCY) begin : g_bad_depth
        $error("l2_bank_rsp_pipe: DEPTH must be 1..%0d", MAX_READ_LATENCY);
    end

    always_comb begin
        valid_d    = valid_q;
        err_d      = err_q;
        valid_d[0] = valid_i;
        err_d[0]   = err_i;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign err_o   = err_q[DEPTH-1];

endmodule

// File: rtl/l2_bank_ctrl.sv
// Per-bank L2 SRAM front-end: single TCDM slave port, out-of-window error
// responses and a zero-fill init sequencer.
module l2_bank_ctrl
    import l2_bank_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          BYTE_WIDTH    = 8,
    parameter int          ADDR_WIDTH    = 15,
    parameter logic [31:0] BASE_ADDR     = 32'h1C00_0000,
    parameter int          READ_LATENCY  = 1,
    parameter int          INIT_ON_RESET = 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        init_req_i,
    output logic                                        init_busy_o,
    output logic                                        init_done_o,
    input  logic                                        req_i,
    output logic                                        gnt_o,
    input  logic [31:0]                                 add_i,
    input  logic                                        wen_i,
    input  logic [be_width(DATA_WIDTH, BYTE_WIDTH)-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]                       wdata_i,
    output logic                                        r_valid_o,
    output logic [DATA_WIDTH-1:0]                       r_rdata_o,
    output logic                                        r_opc_o,
    output logic                                        mem_csn_o,
    output logic                                        mem_wen_o,
    output logic [be_width(DATA_WIDTH, BYTE_WIDTH)-1:0] mem_ben_o,
    output logic [ADDR_WIDTH-1:0]                       mem_addr_o,
    output logic [DATA_WIDTH-1:0]                       mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                       mem_rdata_i
);

    localparam l2_bank_state_e        RST_STATE = (INIT_ON_RESET != 0) ? INIT : SERVE;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = 1;

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("l2_bank_ctrl: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
        $error("l2_bank_ctrl: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    l2_bank_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [31:0]           off;
    logic                  in_range;
    logic                  rsp_valid, rsp_err;

    // Window check: addresses below BASE_ADDR wrap to huge offsets and fail it.
    assign off      = add_i - BASE_ADDR;
    assign in_range = ((off >> (ADDR_WIDTH + 2)) == 32'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        gnt_o       = 1'b0;
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_ben_o   = '1;
        mem_addr_o  = off[ADDR_WIDTH+1:2];
        mem_wdata_o = wdata_i;
        // While reset is held the state already shows its reset target, but
        // the port must stay idle and refuse requests.
        if (!rst_i) begin
            unique case (state_q)
                INIT: begin
                    mem_csn_o   = 1'b0;
                    mem_wen_o   = 1'b0;
                    mem_ben_o   = '0;
                    mem_addr_o  = cnt_q;
                    mem_wdata_o = '0;
                    cnt_d       = cnt_q + CNT_ONE;
                    if (cnt_q == '1) begin
                        state_d = SERVE;
                        done_d  = 1'b1;
                    end
                end
                SERVE: begin
                    gnt_o     = req_i;
                    mem_csn_o = ~(req_i & in_range);
                    mem_wen_o = wen_i;
                    mem_ben_o = ~be_i;
                    cnt_d     = '0;
                    if (init_req_i) begin
                        state_d = INIT;
                    end
                end
                default: state_d = RST_STATE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign rsp_valid = req_i & gnt_o;
    assign rsp_err   = req_i & gnt_o & ~in_range;

    l2_bank_rsp_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rsp_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (rsp_valid),
        .err_i   (rsp_err),
        .valid_o (r_valid_o),
        .err_o   (r_opc_o)
    );

    assign r_rdata_o   = (r_valid_o & ~r_opc_o) ? mem_rdata_i : '0;
    assign init_busy_o = (state_q == INIT);
    assign init_done_o = done_q;

endmodule

// File: tb/tb_l2_bank_ctrl.sv
// Scoreboard bench: two banks (latency 3 with init-on-reset, latency 2 without).
module tb_l2_bank_ctrl;

    localparam logic [31:0] BASE = 32'h1C00_0000;

    typedef struct {
        int          due;
        logic        opc;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit fin_a  = 1'b0;
    bit fin_b  = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    // ---------------- bank A: ADDR_WIDTH 4, READ_LATENCY 3, INIT_ON_RESET 1
    logic        rst_a, init_req_a, init_busy_a, init_done_a, req_a, gnt_a, wen_a;
    logic [31:0] add_a, wdata_a, rdata_a, mwdata_a, mrdata_a;
    logic [3:0]  be_a, mben_a, maddr_a;
    logic        rvalid_a, ropc_a, csn_a, mwen_a;

    l2_bank_ctrl #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .BASE_ADDR(BASE),
        .READ_LATENCY(3), .INIT_ON_RESET(1)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .init_req_i(init_req_a),
        .init_busy_o(init_busy_a), .init_done_o(init_done_a),
        .req_i(req_a), .gnt_o(gnt_a), .add_i(add_a), .wen_i(wen_a), .be_i(be_a),
        .wdata_i(wdata_a), .r_valid_o(rvalid_a), .r_rdata_o(rdata_a), .r_opc_o(ropc_a),
        .mem_csn_o(csn_a), .mem_wen_o(mwen_a), .mem_ben_o(mben_a), .mem_addr_o(maddr_a),
        .mem_wdata_o(mwdata_a), .mem_rdata_i(mrdata_a)
    );

    // ---------------- bank B: ADDR_WIDTH 4, READ_LATENCY 2, INIT_ON_RESET 0
    logic        rst_b, init_req_b, init_busy_b, init_done_b, req_b, gnt_b, wen_b;
    logic [31:0] add_b, wdata_b, rdata_b, mwdata_b, mrdata_b;
    logic [3:0]  be_b, mben_b, maddr_b;
    logic        rvalid_b, ropc_b, csn_b, mwen_b;

    l2_bank_ctrl #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .BASE_ADDR(BASE),
        .READ_LATENCY(2), .INIT_ON_RESET(0)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .init_req_i(init_req_b),
        .init_busy_o(init_busy_b), .init_done_o(init_done_b),
        .req_i(req_b), .gnt_o(gnt_b), .add_i(add_b), .wen_i(wen_b), .be_i(be_b),
        .wdata_i(wdata_b), .r_valid_o(rvalid_b), .r_rdata_o(rdata_b), .r_opc_o(ropc_b),
        .mem_csn_o(csn_b), .mem_wen_o(mwen_b), .mem_ben_o(mben_b), .mem_addr_o(maddr_b),
        .mem_wdata_o(mwdata_b), .mem_rdata_i(mrdata_b)
    );

    // ---------------- SRAM models: byte-masked writes, pipelined reads, garbage when not reading
    logic [31:0] mem_a [16];
    logic [31:0] rp_a [3];
    bit          minit_a = 1'b0;
    always @(posedge clk) begin
        if (!minit_a) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= 32'hA5A5_0000 + i;
            minit_a <= 1'b1;
        end else if (!csn_a && !mwen_a) begin
            for (int b = 0; b < 4; b++)
                if (!mben_a[b]) mem_a[maddr_a][8*b +: 8] <= mwdata_a[8*b +: 8];
        end
        rp_a[0] <= (!csn_a && mwen_a) ? mem_a[maddr_a] : 32'hBAD0_BAD0;
        rp_a[1] <= rp_a[0];
        rp_a[2] <= rp_a[1];
    end
    assign mrdata_a = rp_a[2];

    logic [31:0] mem_b [16];
    logic [31:0] rp_b [2];
    bit          minit_b = 1'b0;
    always @(posedge clk) begin
        if (!minit_b) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= 32'h5A5A_0000 + i;
            minit_b <= 1'b1;
        end else if (!csn_b && !mwen_b) begin
            for (int b = 0; b < 4; b++)
                if (!mben_b[b]) mem_b[maddr_b][8*b +: 8] <= mwdata_b[8*b +: 8];
        end
        rp_b[0] <= (!csn_b && mwen_b) ? mem_b[maddr_b] : 32'hBAD0_BAD0;
        rp_b[1] <= rp_b[0];
    end
    assign mrdata_b = rp_b[1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- response monitors
    always @(negedge clk) begin
        if (rvalid_a === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL rsp_a unexpected response opc %0b rdata %h at cycle %0d", ropc_a, rdata_a, cyc);
            end else begin
                ea = qa.pop_front();
                if (cyc != ea.due || ropc_a !== ea.opc || (ea.chk && rdata_a !== ea.data)) begin
                    errors++;
                    $display("FAIL rsp_a got cycle %0d opc %0b rdata %h want cycle %0d opc %0b rdata %h",
                             cyc, ropc_a, rdata_a, ea.due, ea.opc, ea.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rvalid_b === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL rsp_b unexpected response opc %0b rdata %h at cycle %0d", ropc_b, rdata_b, cyc);
            end else begin
                eb = qb.pop_front();
                if (cyc != eb.due || ropc_b !== eb.opc || (eb.chk && rdata_b !== eb.data)) begin
                    errors++;
                    $display("FAIL rsp_b got cycle %0d opc %0b rdata %h want cycle %0d opc %0b rdata %h",
                             cyc, ropc_b, rdata_b, eb.due, eb.opc, eb.data);
                end
            end
        end
    end

    // ---------------- stimulus helpers (called #1 after a posedge)
    task automatic issue_a(input logic w, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, input logic oor, input logic ck,
                           input logic [31:0] ed);
        logic [3:0] nbe;
        exp_t       e;
        nbe   = ~be;
        req_a = 1'b1; wen_a = w; add_a = a; be_a = be; wdata_a = d;
        @(negedge clk);
        chk("gnt_a", gnt_a, 1);
        chk("csn_a", csn_a, oor);
        if (!oor) begin
            chk("mem_wen_a", mwen_a, w);
            chk("mem_ben_a", mben_a, nbe);
        end
        e.due = cyc + 3; e.opc = oor; e.chk = ck; e.data = ed;
        qa.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic issue_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic ck, input logic [31:0] ed);
        exp_t e;
        req_b = 1'b1; wen_b = w; add_b = a; be_b = 4'hF; wdata_b = d;
        @(negedge clk);
        chk("gnt_b", gnt_b, 1);
        chk("csn_b", csn_b, 0);
        e.due = cyc + 2; e.opc = 1'b0; e.chk = ck; e.data = ed;
        qb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain_a();
        for (int k = 0; k < 12 && qa.size() != 0; k++) @(negedge clk);
        chk("drain_a", qa.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic sweep_a(input logic exp_done, input logic exp_gnt_after);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("sweep_csn", csn_a, 0);
            chk("sweep_wen", mwen_a, 0);
            chk("sweep_ben", mben_a, 0);
            chk("sweep_addr", maddr_a, i);
            chk("sweep_wdata", mwdata_a, 0);
            chk("sweep_gnt", gnt_a, 0);
            chk("sweep_busy", init_busy_a, 1);
            chk("sweep_done", init_done_a, exp_done);
            if (i == 3) init_req_a = 1'b0;
        end
        @(negedge clk);
        chk("post_done", init_done_a, 1);
        chk("post_busy", init_busy_a, 0);
        chk("post_gnt", gnt_a, exp_gnt_after);
    endtask

    // ---------------- bank A sequence
    initial begin
        exp_t e;
        rst_a = 1'b1; init_req_a = 1'b0; req_a = 1'b1; wen_a = 1'b1;
        add_a = BASE; be_a = 4'hF; wdata_a = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt_a, 0);
        chk("rst_csn", csn_a, 1);
        chk("rst_wen", mwen_a, 1);
        chk("rst_valid", rvalid_a, 0);
        chk("rst_opc", ropc_a, 0);
        chk("rst_rdata", rdata_a, 0);
        chk("rst_busy", init_busy_a, 1);
        chk("rst_done", init_done_a, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;

        // Zero-fill after reset with a read of word 0 held pending.
        sweep_a(1'b0, 1'b1);
        e.due = cyc + 3; e.opc = 1'b0; e.chk = 1'b1; e.data = 32'h0;
        qa.push_back(e);
        @(posedge clk); #1;
        req_a = 1'b0;
        drain_a();

        // Byte-masked merge and read-back.
        issue_a(1'b0, BASE + 8, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        issue_a(1'b0, BASE + 8, 4'b0001, 32'h0000_00AA, 1'b0, 1'b0, 32'h0);
        issue_a(1'b1, BASE + 8, 4'b1111, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEAA);
        // Window edges: one past the top, one below the base, last word with ignored low bits.
        issue_a(1'b1, BASE + 64, 4'b1111, 32'h0,        1'b1, 1'b1, 32'h0);
        issue_a(1'b1, BASE - 4,  4'b1111, 32'h0,        1'b1, 1'b1, 32'h0);
        issue_a(1'b0, BASE + 60, 4'b1111, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        issue_a(1'b1, BASE + 63, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h1234_5678);
        req_a = 1'b0;
        drain_a();

        // init request coinciding with a granted read; a held read waits for the sweep.
        req_a = 1'b1; wen_a = 1'b1; add_a = BASE + 8; init_req_a = 1'b1;
        @(negedge clk);
        chk("initreq_gnt", gnt_a, 1);
        e.due = cyc + 3; e.opc = 1'b0; e.chk = 1'b1; e.data = 32'hDEAD_BEAA;
        qa.push_back(e);
        @(posedge clk); #1;
        add_a = BASE + 60;
        sweep_a(1'b1, 1'b1);
        e.due = cyc + 3; e.opc = 1'b0; e.chk = 1'b1; e.data = 32'h0;
        qa.push_back(e);
        @(posedge clk); #1;
        req_a = 1'b0;
        drain_a();

        // Reset mid-sweep at counter 5.
        init_req_a = 1'b1;
        @(posedge clk); #1;
        init_req_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("pre_rst_addr", maddr_a, i);
        end
        rst_a = 1'b1; req_a = 1'b1;
        @(negedge clk);
        chk("mid_rst_csn", csn_a, 1);
        chk("mid_rst_wen", mwen_a, 1);
        chk("mid_rst_gnt", gnt_a, 0);
        chk("mid_rst_valid", rvalid_a, 0);
        chk("mid_rst_busy", init_busy_a, 1);
        chk("mid_rst_done", init_done_a, 0);
        @(posedge clk); #1;
        rst_a = 1'b0; req_a = 1'b0;
        sweep_a(1'b0, 1'b0);
        @(posedge clk); #1;
        fin_a = 1'b1;
    end

    // ---------------- bank B sequence: back-to-back traffic at latency 2
    logic [31:0] wv [8] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                            32'hCAFE_F00D, 32'h0F0F_0F0F, 32'h7FFF_FFFF, 32'hA5A5_5A5A};

    initial begin
        rst_b = 1'b1; init_req_b = 1'b0; req_b = 1'b1; wen_b = 1'b1;
        add_b = BASE; be_b = 4'hF; wdata_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b_rst_busy", init_busy_b, 0);
        chk("b_rst_done", init_done_b, 0);
        chk("b_rst_gnt", gnt_b, 0);
        chk("b_rst_csn", csn_b, 1);
        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) issue_b(1'b0, BASE + 4*i, wv[i], 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) issue_b(1'b1, BASE + 4*(7-i), 32'h0, 1'b1, wv[7-i]);
        req_b = 1'b0;
        for (int k = 0; k < 12 && qb.size() != 0; k++) @(negedge clk);
        chk("drain_b", qb.size(), 0);
        chk("b_end_busy", init_busy_b, 0);
        chk("b_end_done", init_done_b, 0);
        fin_b = 1'b1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        wait (fin_a && fin_b);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_bank_ctrl.md
Name: l2_bank_ctrl

Overview:
Parametrised per-bank front-end for L2 SRAM banks, interleaved or private, one instance per bank. Serves a single TCDM slave port with a configurable SRAM read latency, and returns an error response for out-of-window addresses. A built-in init sequencer zero-fills the bank after reset or on request. The SoC L2 wrapper instantiates NB_BANKS of these; the SRAM macro or FPGA RAM sits behind the mem_* port.

Parameters:
DATA_WIDTH, 32, data bits per word (36 allowed with BYTE_WIDTH 9)
BYTE_WIDTH, 8, bits per byte-enable lane; DATA_WIDTH % BYTE_WIDTH == 0
ADDR_WIDTH, 15, word-address bits; bank depth = 2**ADDR_WIDTH words
BASE_ADDR, 32'h1C00_0000, byte address of bank word 0 (after interleave stripping)
READ_LATENCY, 1, SRAM clock-to-Q cycles, 1..4
INIT_ON_RESET, 1, 1: zero-fill automatically after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
init_req_i  in  1  pulse: start a zero-fill sweep
init_busy_o  out  1  sweep in progress
init_done_o  out  1  sticky: at least one sweep has completed since reset
req_i  in  1  TCDM request
gnt_o  out  1  TCDM grant
add_i  in  32  byte address
wen_i  in  1  1 = read, 0 = write
be_i  in  DATA_WIDTH/BYTE_WIDTH  byte enables, active-high
wdata_i  in  DATA_WIDTH  write data
r_valid_o  out  1  response valid
r_rdata_o  out  DATA_WIDTH  read data
r_opc_o  out  1  1 = error (out of window)
mem_csn_o  out  1  SRAM chip select, active-low
mem_wen_o  out  1  SRAM write enable, active-low
mem_ben_o  out  DATA_WIDTH/BYTE_WIDTH  SRAM byte enables, active-low
mem_addr_o  out  ADDR_WIDTH  SRAM word address
mem_wdata_o  out  DATA_WIDTH  SRAM write data
mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid READ_LATENCY cycles after access

Behaviour:
- Reset values:
  - gnt_o=0, r_valid_o=0, r_opc_o=0, r_rdata_o=0.
  - mem_csn_o=1, mem_wen_o=1.
  - init_busy_o = INIT_ON_RESET, init_done_o=0.
  - Init counter 0; response pipeline cleared.
- FSM states: INIT, SERVE.
  - After reset: INIT if INIT_ON_RESET, else SERVE.
  - SERVE -> INIT on init_req_i=1.
  - INIT -> SERVE on the cycle the counter writes 2**ADDR_WIDTH-1.
- INIT state:
  - gnt_o=0 regardless of req_i.
  - Each cycle: mem_csn_o=0, mem_wen_o=0, mem_ben_o all 0, mem_addr_o=counter, mem_wdata_o=0; counter increments.
  - Sweep length is exactly 2**ADDR_WIDTH cycles.
  - init_busy_o=1 throughout. init_done_o sets the cycle after the last write and stays set until reset.
  - init_req_i during INIT is ignored; the sweep does not restart.
  - Reset mid-sweep: counter returns to 0; the sweep restarts if INIT_ON_RESET, else the FSM returns to SERVE.
- SERVE state:
  - gnt_o = req_i, combinational; every request is accepted in one cycle.
  - off = add_i - BASE_ADDR, 32-bit wrap.
  - In range when off < 4*2**ADDR_WIDTH. add_i below BASE_ADDR wraps and is therefore out of range.
  - In range: mem_csn_o=0, mem_wen_o=wen_i, mem_ben_o=~be_i, mem_addr_o=off[ADDR_WIDTH+1:2], mem_wdata_o=wdata_i.
  - Out of range: mem_csn_o=1 (no SRAM access) and the error bit is queued.
  - off[1:0] is ignored.
- Response pipeline:
  - Two shift registers, valid and err, each READ_LATENCY stages deep.
  - Stage 0 loads req_i & gnt_o and the out-of-range flag.
  - r_valid_o and r_opc_o come from the last stage.
  - Fixed latency READ_LATENCY cycles from grant to r_valid_o, for reads and writes alike.
  - r_rdata_o = mem_rdata_i when r_valid_o & ~r_opc_o, otherwise 0.
  - Back-to-back requests produce back-to-back responses with no bubbles.
- init_req_i in SERVE:
  - A request presented in that same cycle is still granted and served.
  - Responses already in the pipeline complete normally during INIT.
  - INIT starts the next cycle.

Decomposition:
- Package l2_bank_pkg holds:
  - state enum l2_bank_state_e {INIT, SERVE}
  - function be_width(DATA_WIDTH, BYTE_WIDTH)
  - constant for the maximum READ_LATENCY (4)
- Sub-module l2_bank_rsp_pipe: parametrised valid/err shift register, depth READ_LATENCY, synchronous active-high reset.
- Parameter checks at elaboration time: READ_LATENCY in 1..4; DATA_WIDTH % BYTE_WIDTH == 0.

Test Plan:
1. ADDR_WIDTH=4, INIT_ON_RESET=1; release reset -> 16 consecutive zero writes to addr 0..15; gnt_o=0 throughout; init_done_o=1 on cycle 17; init_busy_o then low.
2. READ_LATENCY=3:
   - Write 0xDEADBEEF at BASE_ADDR+8 with be=4'b1111.
   - Write 0x000000AA at the same address with be=4'b0001.
   - Read BASE_ADDR+8 -> r_valid_o exactly 3 cycles after grant; r_rdata_o=0xDEADBEAA; r_opc_o=0.
3. Read BASE_ADDR+4*2**ADDR_WIDTH, then read BASE_ADDR-4 -> each: gnt_o=1, mem_csn_o=1, r_valid_o after latency with r_opc_o=1 and r_rdata_o=0.
4. 8 back-to-back reads at READ_LATENCY=2 -> 8 consecutive r_valid_o cycles starting 2 cycles after the first grant; data in request order.
5. init_req_i asserted with a read granted the same cycle -> read response still delivered with correct pre-init data; request held during the sweep is not granted until the sweep ends.
6. Assert rst_i at counter=5 mid-sweep -> outputs return to reset values next cycle; sweep restarts at addr 0; init_done_o stays 0 until the full sweep completes.
